// File: rtl/amem_wr_arbiter.sv
// amem_wr_arbiter: round-robin write-port arbiter and burst sequencer for the
// asymmetric envelope/waveform memory. Serialises requester bursts onto the
// single wide write port, auto-increments the address, and reports completion
// only after the memory's write pipeline has committed the final word.
module amem_wr_arbiter #(
    parameter int NREQ       = 2,
    parameter int ADDRWIDTHA = 8,
    parameter int DATAWIDTHA = 16,
    parameter int LENWIDTH   = 8,
    parameter int WR_LAT     = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NREQ-1:0]              cmd_valid,
    output logic [NREQ-1:0]              cmd_ready,
    input  logic [NREQ*ADDRWIDTHA-1:0]   cmd_addr,
    input  logic [NREQ*LENWIDTH-1:0]     cmd_len,
    input  logic [NREQ-1:0]              d_valid,
    output logic [NREQ-1:0]              d_ready,
    input  logic [NREQ*DATAWIDTHA-1:0]   d_data,
    output logic [NREQ-1:0]              done,
    output logic                         busy,
    output logic                         weA,
    output logic [ADDRWIDTHA-1:0]        addrA,
    output logic [DATAWIDTHA-1:0]        diA
);

    localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DCW = (WR_LAT > 0) ? $clog2(WR_LAT + 1) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic                  armed;
    logic [GW-1:0]         rrPtr;
    logic [GW-1:0]         gnt;
    logic [GW-1:0]         arbGnt;
    logic                  arbHit;
    logic [ADDRWIDTHA-1:0] curAddr;
    logic [LENWIDTH-1:0]   remain;
    logic [DCW-1:0]        drainCnt;
    logic                  cmdFire;
    logic                  dataFire;

    logic [ADDRWIDTHA-1:0] reqAddr [NREQ];
    logic [LENWIDTH-1:0]   reqLen  [NREQ];
    logic [DATAWIDTHA-1:0] reqData [NREQ];

    // Requester index k positions after base, wrapping at NREQ (NREQ need not be a power of two).
    function automatic logic [GW-1:0] rrIndex(input logic [GW-1:0] base, input int k);
        return GW'((int'(base) + k) % NREQ);
    endfunction

    // Unpack the flat per-requester buses into arrays indexed by requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqAddr[i] = cmd_addr[i*ADDRWIDTHA +: ADDRWIDTHA];
            reqLen[i]  = cmd_len[i*LENWIDTH +: LENWIDTH];
            reqData[i] = d_data[i*DATAWIDTHA +: DATAWIDTHA];
        end
    end

    // Round-robin search: first valid command starting just after the last grant.
    always_comb begin
        arbGnt = '0;
        arbHit = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!arbHit && cmd_valid[rrIndex(rrPtr, k)]) begin
                arbGnt = rrIndex(rrPtr, k);
                arbHit = 1'b1;
            end
        end
    end

    // Handshake readies; both held low until the block is armed after reset.
    always_comb begin
        cmd_ready = '0;
        d_ready   = '0;
        if (armed && (state == IDLE) && arbHit) begin
            cmd_ready[arbGnt] = 1'b1;
        end
        if (armed && (state == BURST)) begin
            d_ready[gnt] = 1'b1;
        end
    end

    assign cmdFire  = |(cmd_valid & cmd_ready);
    assign dataFire = |(d_valid & d_ready);

    // Arm one edge after reset release so no handshake can land in that first cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Burst sequencer: accept command, count words, then wait out the memory write pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rrPtr    <= GW'(NREQ - 1);
            gnt      <= '0;
            curAddr  <= '0;
            remain   <= '0;
            drainCnt <= '0;
            busy     <= 1'b0;
            done     <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (cmdFire) begin
                        gnt     <= arbGnt;
                        rrPtr   <= arbGnt;
                        curAddr <= reqAddr[arbGnt];
                        remain  <= reqLen[arbGnt];
                        busy    <= 1'b1;
                        state   <= BURST;
                    end
                end
                BURST: begin
                    if (dataFire) begin
                        // Address wraps naturally from all-ones to zero.
                        curAddr <= curAddr + 1'b1;
                        if (remain == '0) begin
                            drainCnt <= DCW'(WR_LAT);
                            state    <= DRAIN;
                        end else begin
                            remain <= remain - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drainCnt == '0) begin
                        done[gnt] <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        drainCnt <= drainCnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered memory write port; address and data hold their last value between writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weA   <= 1'b0;
            addrA <= '0;
            diA   <= '0;
        end else begin
            weA <= dataFire;
            if (dataFire) begin
                addrA <= curAddr;
                diA   <= reqData[gnt];
            end
        end
    end

endmodule
